// File: rtl/synth_mmio_pkg.sv
// Shared constants for the synth MMIO register file: address map, sel encodings,
// voice window geometry and the duty hand-off state encoding.
package synth_mmio_pkg;

    localparam logic [2:0] SEL_LOAD   = 3'd1;
    localparam logic [2:0] SEL_STORE  = 3'd2;
    localparam logic [2:0] SEL_J_OR_B = 3'd6;
    localparam logic [2:0] SEL_X      = 3'd7;

    localparam logic [15:0] ADDR_CC          = 16'h0010;
    localparam logic [15:0] ADDR_IC          = 16'h0014;
    localparam logic [15:0] ADDR_CNT_RST     = 16'h0018;
    localparam logic [15:0] ADDR_LEDS        = 16'h0030;
    localparam logic [15:0] ADDR_DUTY        = 16'h0034;
    localparam logic [15:0] ADDR_DUTY_STATUS = 16'h0040;
    localparam logic [15:0] ADDR_SOURCE      = 16'h0044;
    localparam logic [15:0] ADDR_GSR         = 16'h0100;
    localparam logic [15:0] ADDR_GAIN        = 16'h0104;
    localparam logic [15:0] ADDR_IRQ_MASK    = 16'h0108;
    localparam logic [15:0] ADDR_SINE        = 16'h0200;
    localparam logic [15:0] ADDR_SQUARE      = 16'h0204;
    localparam logic [15:0] ADDR_TRIANGLE    = 16'h0208;
    localparam logic [15:0] ADDR_SAWTOOTH    = 16'h020C;

    localparam logic [15:0] VOICE_BASE   = 16'h1000;
    localparam int          VOICE_STRIDE = 32;

    localparam int OFF_FCW      = 0;
    localparam int OFF_START    = 4;
    localparam int OFF_RELEASE  = 8;
    localparam int OFF_FINISHED = 12;
    localparam int OFF_RESET    = 16;

    typedef enum logic [1:0] {
        DUTY_IDLE     = 2'd0,
        DUTY_REQ      = 2'd1,
        DUTY_WAIT_LOW = 2'd2
    } duty_state_e;

endpackage

// File: rtl/synth_mmio_regs_req_ack.sv
// Duty-cycle hand-off: shadow register, pending flag and a 4-phase req/ack FSM
// that only changes duty_cycle while duty_req is low.
module synth_req_ack_fsm
    import synth_mmio_pkg::*;
#(
    parameter int DUTY_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DUTY_W-1:0] wdata,
    input  logic              duty_ack,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_req,
    output logic              busy,
    output logic              pending
);

    duty_state_e       state, state_nxt;
    logic [DUTY_W-1:0] shadow;
    logic              launch;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= DUTY_IDLE;
            shadow     <= '0;
            pending    <= 1'b0;
            duty_cycle <= '0;
        end else begin
            state <= state_nxt;
            if (wr) shadow <= wdata;
            // a store landing on the launch edge stays pending for the next transfer
            if (wr) pending <= 1'b1;
            else if (launch) pending <= 1'b0;
            if (launch) duty_cycle <= shadow;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            DUTY_IDLE: begin
                if (pending) begin
                    launch    = 1'b1;
                    state_nxt = DUTY_REQ;
                end
            end
            DUTY_REQ:      if (duty_ack)  state_nxt = DUTY_WAIT_LOW;
            DUTY_WAIT_LOW: if (!duty_ack) state_nxt = DUTY_IDLE;
            default:       state_nxt = DUTY_IDLE;
        endcase
    end

    assign duty_req = (state == DUTY_REQ);
    assign busy     = (state != DUTY_IDLE);

endmodule

// File: rtl/synth_mmio_regs.sv
// MMIO control/status register file for an N-voice synth.
// Optional finished-note interrupt: define SYNTH_MMIO_FINISH_IRQ_EN.
module synth_mmio_regs
    import synth_mmio_pkg::*;
#(
    parameter int N_VOICES = 4,
    parameter int FCW_W    = 24,
    parameter int DUTY_W   = 12,
    parameter int ADDR_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [2:0]                sel,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic [N_VOICES*FCW_W-1:0] voice_fcw,
    output logic [N_VOICES-1:0]       note_start,
    output logic [N_VOICES-1:0]       note_release,
    output logic [N_VOICES-1:0]       note_reset,
    input  logic [N_VOICES-1:0]       note_finished,
    output logic [4:0]                sine_shift,
    output logic [4:0]                square_shift,
    output logic [4:0]                triangle_shift,
    output logic [4:0]                sawtooth_shift,
    output logic [4:0]                global_gain,
    output logic                      dac_source,
    output logic [DUTY_W-1:0]         duty_cycle,
    output logic                      duty_req,
    input  logic                      duty_ack,
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
    output logic                      irq,
`endif
    output logic [5:0]                leds
);

    logic                is_load, is_store, gsr_wr, cnt_clr, duty_wr;
    logic                duty_busy, duty_pending;
    logic [31:0]         cc, ic, cc_nxt, ic_nxt, rd_val;
    logic [N_VOICES-1:0] sticky, wr_start, wr_release, wr_reset, wr_fcw, gsr_vec;
    logic [ADDR_W-1:0]   vrel;
    logic                in_win;
    int                  vidx, voff;
    logic                unused_ok;
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
    logic [N_VOICES-1:0] irq_mask;
`endif

    function automatic logic is_at(input logic [ADDR_W-1:0] a, input logic [15:0] c);
        return a == ADDR_W'(c);
    endfunction

    assign is_load  = en && (sel == SEL_LOAD);
    assign is_store = en && (sel == SEL_STORE);
    assign gsr_wr   = is_store && is_at(addr, ADDR_GSR);
    assign cnt_clr  = is_store && is_at(addr, ADDR_CNT_RST);
    assign duty_wr  = is_store && is_at(addr, ADDR_DUTY);
    assign gsr_vec  = {N_VOICES{gsr_wr}};
    assign unused_ok = ^wdata;

    // the clear outranks that cycle's increment; loads observe the post-edge count
    assign cc_nxt = cnt_clr ? 32'd0 : cc + 32'd1;
    assign ic_nxt = cnt_clr ? 32'd0 : ((en && sel != SEL_J_OR_B) ? ic + 32'd1 : ic);

    assign vrel   = addr - ADDR_W'(VOICE_BASE);
    assign in_win = (addr >= ADDR_W'(VOICE_BASE)) && (int'(vrel) < N_VOICES * VOICE_STRIDE);
    assign vidx   = int'(vrel) / VOICE_STRIDE;
    assign voff   = int'(vrel) % VOICE_STRIDE;

    always_comb begin
        wr_fcw     = '0;
        wr_start   = '0;
        wr_release = '0;
        wr_reset   = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (is_store && in_win && vidx == v) begin
                wr_fcw[v]     = (voff == OFF_FCW);
                wr_start[v]   = (voff == OFF_START);
                wr_release[v] = (voff == OFF_RELEASE);
                wr_reset[v]   = (voff == OFF_RESET);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_at(addr, ADDR_CC))          rd_val = cc_nxt;
        if (is_at(addr, ADDR_IC))          rd_val = ic_nxt;
        if (is_at(addr, ADDR_DUTY_STATUS)) rd_val = {30'd0, duty_pending, duty_busy};
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
        if (is_at(addr, ADDR_IRQ_MASK))    rd_val = 32'(irq_mask);
`endif
        for (int v = 0; v < N_VOICES; v++) begin
            if (in_win && vidx == v && voff == OFF_FCW)      rd_val = 32'(voice_fcw[v*FCW_W +: FCW_W]);
            if (in_win && vidx == v && voff == OFF_FINISHED) rd_val = 32'(sticky[v]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata          <= '0;
            voice_fcw      <= '0;
            note_start     <= '0;
            note_release   <= '0;
            note_reset     <= '0;
            sticky         <= '0;
            sine_shift     <= '0;
            square_shift   <= '0;
            triangle_shift <= '0;
            sawtooth_shift <= '0;
            global_gain    <= '0;
            dac_source     <= 1'b0;
            leds           <= '0;
            cc             <= '0;
            ic             <= '0;
        end else begin
            cc           <= cc_nxt;
            ic           <= ic_nxt;
            note_start   <= wr_start;
            note_release <= wr_release;
            note_reset   <= wr_reset | gsr_vec;
            // clear beats a simultaneous set
            sticky       <= (sticky | note_finished) & ~(wr_start | wr_reset | gsr_vec);
            if (is_load) rdata <= rd_val;
            for (int v = 0; v < N_VOICES; v++) begin
                if (wr_fcw[v]) voice_fcw[v*FCW_W +: FCW_W] <= wdata[FCW_W-1:0];
            end
            if (is_store) begin
                if (is_at(addr, ADDR_LEDS))     leds           <= wdata[5:0];
                if (is_at(addr, ADDR_SOURCE))   dac_source     <= wdata[0];
                if (is_at(addr, ADDR_GAIN))     global_gain    <= wdata[4:0];
                if (is_at(addr, ADDR_SINE))     sine_shift     <= wdata[4:0];
                if (is_at(addr, ADDR_SQUARE))   square_shift   <= wdata[4:0];
                if (is_at(addr, ADDR_TRIANGLE)) triangle_shift <= wdata[4:0];
                if (is_at(addr, ADDR_SAWTOOTH)) sawtooth_shift <= wdata[4:0];
            end
        end
    end

`ifdef SYNTH_MMIO_FINISH_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (is_store && is_at(addr, ADDR_IRQ_MASK)) irq_mask <= wdata[N_VOICES-1:0];
            irq <= |(sticky & irq_mask);
        end
    end
`endif

    synth_req_ack_fsm #(
        .DUTY_W(DUTY_W)
    ) u_duty (
        .clk       (clk),
        .rst       (rst),
        .wr        (duty_wr),
        .wdata     (wdata[DUTY_W-1:0]),
        .duty_ack  (duty_ack),
        .duty_cycle(duty_cycle),
        .duty_req  (duty_req),
        .busy      (duty_busy),
        .pending   (duty_pending)
    );

endmodule

// File: tb/tb_synth_mmio_regs.sv
// Bench for synth_mmio_regs: directed steps plus randomized traffic checked
// against an address-map level reference model.
module tb_synth_mmio_regs;

    localparam int N = 4;
    localparam logic [2:0] LD = 3'd1, ST = 3'd2, JB = 3'd6, XX = 3'd7;

    logic          clk = 1'b0;
    logic          rst, en, dac_source, duty_req, duty_ack, irq;
    logic [15:0]   addr;
    logic [2:0]    sel;
    logic [31:0]   wdata, rdata;
    logic [N*24-1:0] voice_fcw;
    logic [N-1:0]  note_start, note_release, note_reset, note_finished;
    logic [4:0]    sine_shift, square_shift, triangle_shift, sawtooth_shift, global_gain;
    logic [11:0]   duty_cycle;
    logic [5:0]    leds;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0]  cc_m, ic_m, rd_m, r1;
    logic [23:0]  fcw_m [N];
    logic [N-1:0] sticky_m, mask_m, ps_m, pr_m, pz_m;
    logic         irq_m;

    localparam logic [15:0] GA [11] = '{16'h0010, 16'h0014, 16'h0018, 16'h0030, 16'h0044,
                                        16'h0100, 16'h0104, 16'h0108, 16'h0200, 16'h020C, 16'h0300};

    always #5 clk = ~clk;

    synth_mmio_regs #(.N_VOICES(N), .FCW_W(24), .DUTY_W(12), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .sel(sel), .wdata(wdata), .rdata(rdata),
        .voice_fcw(voice_fcw), .note_start(note_start), .note_release(note_release),
        .note_reset(note_reset), .note_finished(note_finished),
        .sine_shift(sine_shift), .square_shift(square_shift), .triangle_shift(triangle_shift),
        .sawtooth_shift(sawtooth_shift), .global_gain(global_gain), .dac_source(dac_source),
        .duty_cycle(duty_cycle), .duty_req(duty_req), .duty_ack(duty_ack),
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
        .irq(irq),
`endif
        .leds(leds)
    );

`ifndef SYNTH_MMIO_FINISH_IRQ_EN
    assign irq = 1'b0;
`endif

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*24-1:0] fcw_flat();
        logic [N*24-1:0] f;
        for (int v = 0; v < N; v++) f[v*24 +: 24] = fcw_m[v];
        return f;
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] a, input logic [31:0] ccn, input logic [31:0] icn);
        int rel;
        if (a == 16'h0010) return ccn;
        if (a == 16'h0014) return icn;
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
        if (a == 16'h0108) return 32'(mask_m);
`endif
        rel = int'(a) - 4096;
        if (rel >= 0 && rel < 32 * N) begin
            if (rel % 32 == 0)  return 32'(fcw_m[rel / 32]);
            if (rel % 32 == 12) return 32'(sticky_m[rel / 32]);
        end
        return 32'd0;
    endfunction

    task automatic cyc(input logic e, input logic [2:0] s, input logic [15:0] a,
                       input logic [31:0] d, input logic [N-1:0] fin);
        logic clr_cnt;
        logic [N-1:0] clr;
        logic [31:0] ccn, icn;
        int rel;
        en = e; sel = s; addr = a; wdata = d; note_finished = fin;
        clr_cnt = e && s == ST && a == 16'h0018;
        ccn = clr_cnt ? 32'd0 : cc_m + 32'd1;
        icn = clr_cnt ? 32'd0 : ((e && s != JB) ? ic_m + 32'd1 : ic_m);
        if (e && s == LD) rd_m = ref_read(a, ccn, icn);
        irq_m = |(sticky_m & mask_m);
        ps_m = '0; pr_m = '0; pz_m = '0; clr = '0;
        if (e && s == ST) begin
            if (a == 16'h0100) begin pz_m = '1; clr = '1; end
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
            if (a == 16'h0108) mask_m = d[N-1:0];
`endif
            rel = int'(a) - 4096;
            if (rel >= 0 && rel < 32 * N) begin
                case (rel % 32)
                    0:  fcw_m[rel / 32] = d[23:0];
                    4:  begin ps_m[rel / 32] = 1'b1; clr[rel / 32] = 1'b1; end
                    8:  pr_m[rel / 32] = 1'b1;
                    16: begin pz_m[rel / 32] = 1'b1; clr[rel / 32] = 1'b1; end
                    default: ;
                endcase
            end
        end
        sticky_m = (sticky_m | fin) & ~clr;
        cc_m = ccn;
        ic_m = icn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, XX, 16'h0000, 32'd0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; sel = XX; addr = '0; wdata = '0; note_finished = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cc_m = 0; ic_m = 0; rd_m = 0; sticky_m = '0; mask_m = '0;
        ps_m = '0; pr_m = '0; pz_m = '0; irq_m = 1'b0;
        for (int v = 0; v < N; v++) fcw_m[v] = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_rdata"}, rdata, rd_m);
        check({tag, "_fcw"}, voice_fcw, fcw_flat());
        check({tag, "_pulses"}, {note_start, note_release, note_reset}, {ps_m, pr_m, pz_m});
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
        check({tag, "_irq"}, irq, irq_m);
`endif
    endtask

    initial begin
        duty_ack = 1'b0;
        do_reset();
        check("rst_rdata", rdata, 32'd0);
        check("rst_fcw", voice_fcw, '0);
        check("rst_pulses", {note_start, note_release, note_reset}, '0);
        check("rst_duty", {duty_req, duty_cycle}, '0);
        check("rst_misc", {leds, global_gain, dac_source, irq}, '0);

        // cycle / instruction counters
        cyc(1'b1, LD, 16'h0010, 0, '0);
        r1 = rdata;
        check("cc_rd1", rdata, rd_m);
        repeat (9) idle();
        cyc(1'b1, LD, 16'h0010, 0, '0);
        check("cc_rd2", rdata, rd_m);
        check("cc_diff", rdata - r1, 32'd10);
        cyc(1'b1, ST, 16'h0018, 32'hFFFF_FFFF, '0);
        cyc(1'b1, LD, 16'h0014, 0, '0);
        check("ic_after_rst", rdata, 32'd1);
        check("ic_model", rdata, rd_m);

        // voice FCW, unmapped voice
        cyc(1'b1, ST, 16'h1040, 32'h00AB_CDEF, '0);
        check("fcw_v2_bits", voice_fcw[71:48], 24'hABCDEF);
        cyc(1'b1, LD, 16'h1040, 0, '0);
        check("fcw_v2_read", rdata, 32'h00AB_CDEF);
        cyc(1'b1, ST, 16'h10A0, 32'h0012_3456, '0);
        check("fcw_v5_ignored", voice_fcw, fcw_flat());
        cyc(1'b1, LD, 16'h10A0, 0, '0);
        check("fcw_v5_read", rdata, 32'd0);

        // START pulse, load of same address does not pulse
        cyc(1'b1, ST, 16'h1024, 32'hDEAD_BEEF, '0);
        check("start_pulse", note_start, 4'b0010);
        idle();
        check("start_gone", note_start, 4'b0000);
        cyc(1'b1, LD, 16'h1024, 0, '0);
        check("start_load_nopulse", {note_start, rdata}, {4'b0000, 32'd0});

        // sticky finished and irq
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
        cyc(1'b1, ST, 16'h0108, 32'h8, '0);
`endif
        cyc(1'b0, XX, 16'h0000, 0, 4'b1000);
        check("irq_not_yet", irq, 1'b0);
        cyc(1'b1, LD, 16'h106C, 0, '0);
        check("fin_v3_set", rdata, 32'd1);
`ifdef SYNTH_MMIO_FINISH_IRQ_EN
        check("irq_rise", irq, 1'b1);
`endif
        repeat (3) idle();
        cyc(1'b1, LD, 16'h106C, 0, '0);
        check("fin_v3_held", rdata, 32'd1);
        cyc(1'b1, ST, 16'h1064, 0, '0);
        cyc(1'b1, LD, 16'h106C, 0, '0);
        check("fin_v3_cleared", rdata, 32'd0);
        check_all("fin");

        // duty hand-off, last store wins while busy
        cyc(1'b1, ST, 16'h0034, 32'h123, '0);
        check("duty_noreq_yet", duty_req, 1'b0);
        cyc(1'b1, ST, 16'h0034, 32'h456, '0);
        check("duty_req1", {duty_req, duty_cycle}, {1'b1, 12'h123});
        idle();
        cyc(1'b1, LD, 16'h0040, 0, '0);
        check("duty_status_busy", rdata, 32'd3);
        check("duty_stable", {duty_req, duty_cycle}, {1'b1, 12'h123});
        duty_ack = 1'b1;
        idle();
        check("duty_req_drop", duty_req, 1'b0);
        duty_ack = 1'b0;
        idle();
        check("duty_wait_low", duty_req, 1'b0);
        idle();
        check("duty_req2", {duty_req, duty_cycle}, {1'b1, 12'h456});
        duty_ack = 1'b1;
        idle();
        duty_ack = 1'b0;
        repeat (3) idle();
        cyc(1'b1, LD, 16'h0040, 0, '0);
        check("duty_status_done", rdata, 32'd0);

        // settings then reset mid-REQ
        cyc(1'b1, ST, 16'h0200, 32'h11, '0);
        cyc(1'b1, ST, 16'h0204, 32'h12, '0);
        cyc(1'b1, ST, 16'h0208, 32'h13, '0);
        cyc(1'b1, ST, 16'h020C, 32'h14, '0);
        cyc(1'b1, ST, 16'h0104, 32'h1F, '0);
        cyc(1'b1, ST, 16'h0030, 32'h2A, '0);
        cyc(1'b1, ST, 16'h0044, 32'h1, '0);
        check("settings", {sine_shift, square_shift, triangle_shift, sawtooth_shift, global_gain, leds, dac_source},
              {5'h11, 5'h12, 5'h13, 5'h14, 5'h1F, 6'h2A, 1'b1});
        cyc(1'b1, ST, 16'h0034, 32'h7, '0);
        idle();
        check("req_before_rst", duty_req, 1'b1);
        do_reset();
        check("rst_midreq", {duty_req, duty_cycle, rdata}, '0);
        check("rst_settings", {sine_shift, square_shift, triangle_shift, sawtooth_shift, global_gain, leds, dac_source}, '0);
        cyc(1'b1, LD, 16'h0040, 0, '0);
        check("rst_fsm_idle", {duty_req, rdata}, '0);

        // global synth reset clears sticky bits and pulses every voice
        cyc(1'b0, XX, 16'h0000, 0, 4'b0101);
        cyc(1'b1, ST, 16'h0100, 0, '0);
        check("gsr_pulse", note_reset, 4'b1111);
        cyc(1'b1, LD, 16'h1000 + 16'h0040 + 16'h000C, 0, '0);
        check_all("gsr");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic [2:0]  s;
            logic        e;
            logic [N-1:0] fin;
            int r;
            if ($urandom_range(0, 9) < 6)
                a = 16'(16'h1000 + 32 * $urandom_range(0, 7) + 4 * $urandom_range(0, 7));
            else
                a = GA[$urandom_range(0, 10)];
            r = $urandom_range(0, 9);
            s = (r < 4) ? LD : (r < 8) ? ST : (r == 8) ? JB : XX;
            e = ($urandom_range(0, 7) != 0);
            fin = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            cyc(e, s, a, $urandom, fin);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
